axis_header_arbiter: RTL and testbench
======================================

# axis_header_arbiter

Packet-level scheduler that shares one `axi_stream_insert_header` instance among `NUM_REQ` header sources. It grants one requester at a time in round-robin order and validates the requester's header descriptor. It forwards the descriptor on the inserter's header port, then holds off the next grant until the inserter's output stream closes the packet (`last_out` beat accepted) or a stall timeout fires.

## Interface
- `DATA_WD`, 32, stream/header width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per beat
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, byte-count field width minus one
- `NUM_REQ`, 4, number of header requesters (≥2)
- `REQ_ID_WD`, `$clog2(NUM_REQ)`, grant index width
- `TIMEOUT_CYC`, 1024, max idle cycles between output beats while busy (0 disables the timeout)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in `NUM_REQ`: per-requester descriptor valid
- `req_header` in `NUM_REQ*DATA_WD`: headers, requester i at `[i*DATA_WD +: DATA_WD]`
- `req_keep` in `NUM_REQ*DATA_BYTE_WD`: header keep masks, same packing
- `req_byte_cnt` in `NUM_REQ*(BYTE_CNT_WD+1)`: header valid-byte counts, same packing
- `req_ready` out `NUM_REQ`: one-hot descriptor accept
- `valid_insert` out 1: to inserter
- `header_insert` out `DATA_WD`: to inserter
- `keep_insert` out `DATA_BYTE_WD`: to inserter
- `byte_insert_cnt` out `BYTE_CNT_WD+1`: to inserter
- `ready_insert` in 1: from inserter
- `mon_valid_out`, `mon_ready_out`, `mon_last_out` in 1 each: taps of the inserter output handshake
- `grant_id` out `REQ_ID_WD`: index of the current or last winner
- `busy` out 1: high from GRANT through BUSY
- `err_desc` out 1: one-cycle pulse when a malformed descriptor is dropped
- `err_timeout` out 1: one-cycle pulse when a BUSY timeout fires

## Operation
- FSM states: IDLE, GRANT, OFFER, BUSY. One-hot, registered.
- IDLE:
  - If `|req_valid`, latch the winner from the round-robin pick and go to GRANT.
  - Search starts at `rr_ptr` and ascends with wrap.
- GRANT (exactly 1 cycle):
  - `req_ready[grant_id]=1`.
  - Capture header, keep and count into output registers.
  - Set `rr_ptr <= (grant_id+1) mod NUM_REQ`.
  - Descriptor is valid iff `1 ≤ byte_cnt ≤ DATA_BYTE_WD` and `keep == (1<<byte_cnt)-1`.
  - Valid descriptor: go to OFFER. Malformed: pulse `err_desc` on the next cycle and return to IDLE without forwarding.
- OFFER:
  - `valid_insert=1`, with the header/keep/count outputs held stable.
  - On `valid_insert && ready_insert`, go to BUSY. No timeout applies here.
- BUSY:
  - Return to IDLE on `mon_valid_out && mon_ready_out && mon_last_out`.
  - `stall_cnt` clears on every accepted output beat and increments otherwise.
  - If `TIMEOUT_CYC!=0` and `stall_cnt==TIMEOUT_CYC-1` with no beat, pulse `err_timeout` and return to IDLE.
- Monitor beats outside BUSY are ignored.
- Requesters must hold `req_valid` and their fields stable until `req_ready`. Deassertion before grant is a protocol violation. The behaviour is then that the captured values are used as they are.

## Timing
- Reset values:
  - state IDLE, `rr_ptr=0`, `grant_id=0`, `stall_cnt=0`.
  - All outputs 0. `req_ready` is decoded from registered state, so it is 0 during reset.
- Latency: `req_valid` seen in IDLE at cycle t gives `req_ready` at t+1 and `valid_insert` at t+2.
- Turnaround: after the last-beat handshake in cycle t, state is IDLE at t+1 and the earliest next `req_ready` is at t+2.
- Simultaneous requests: exactly one grant per arbitration. The requester equal to `rr_ptr` wins first if valid.
- Reset mid-packet: everything returns to reset values immediately and the in-flight descriptor is abandoned. The inserter is reset by the same `rst_n`.
- `err_desc` and `err_timeout` are never high in the same cycle.

## Structure
- Package `axis_hdr_pkg` holds:
  - state encoding constants (`ST_IDLE`, `ST_GRANT`, `ST_OFFER`, `ST_BUSY`)
  - the descriptor-valid function (count range plus keep mask check)
  - a default `TIMEOUT_CYC` constant
- Sub-module `axis_rr_pick`: combinational round-robin picker. It takes `req_valid` and `rr_ptr` and returns `win_id` and `any_valid`. It is instantiated once.
- Counter `stall_cnt` is `$clog2(TIMEOUT_CYC+1)` bits wide and saturates.

## Test plan
- Single requester 2, header 0xA1B2C3D4, cnt 2, keep 4'b0011:
  - `req_ready[2]` at t+1.
  - `valid_insert` at t+2 with the same fields.
  - After the last beat, `busy=0` and `grant_id=2`.
- All four requesters valid continuously, `ready_insert=1`, 3-beat packets: grant order 0,1,2,3,0 with no skips and `busy` gaps of exactly 1 cycle.
- Requester 1 with cnt 5 (`DATA_BYTE_WD=4`), then cnt 2 with keep 4'b0101:
  - `err_desc` pulses twice.
  - `valid_insert` never rises.
  - `rr_ptr` advances to 2.
- `TIMEOUT_CYC=8`, packet granted, `mon_valid_out=0` thereafter: `err_timeout` pulses 8 cycles after BUSY entry and the state returns to IDLE.
- `ready_insert` held low 5 cycles in OFFER: `valid_insert` and the fields remain stable, and no timeout fires.
- `rst_n` asserted in BUSY: all outputs are 0 immediately and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the header arbiter: one-hot state encodings, default timeout and
// the descriptor sanity check.
package axis_hdr_pkg;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_GRANT = 4'b0010;
    localparam logic [3:0] ST_OFFER = 4'b0100;
    localparam logic [3:0] ST_BUSY  = 4'b1000;

    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

    // A descriptor is usable only when its keep mask is exactly the low byte_cnt lanes.
    function automatic logic desc_ok(input logic [63:0] keep, input int unsigned cnt,
                                     input int unsigned nbytes);
        logic [63:0] mask;
        mask = (64'd1 << cnt) - 64'd1;
        return (cnt >= 1) && (cnt <= nbytes) && (keep == mask);
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, with wrap.
module axis_rr_pick #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_ID_WD = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [REQ_ID_WD-1:0] rr_ptr,
    output logic [REQ_ID_WD-1:0] win_id,
    output logic                 any_valid
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_id    = '0;
        any_valid = |req_valid;
        // Walk offsets from farthest to nearest so the nearest valid requester wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (32'(rr_ptr) + 32'(i)) % NUM_REQ;
            if (req_valid[idx]) begin
                win_id = REQ_ID_WD'(idx);
            end
        end
    end

endmodule

// File: rtl/axis_header_arbiter.sv
// Packet-level scheduler sharing one header inserter among NUM_REQ sources; holds each grant
// until the inserter closes the packet or the output stream stalls too long.
module axis_header_arbiter
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned REQ_ID_WD    = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]           req_header,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0]      req_keep,
    input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0]   req_byte_cnt,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 valid_insert,
    output logic [DATA_WD-1:0]                   header_insert,
    output logic [DATA_BYTE_WD-1:0]              keep_insert,
    output logic [BYTE_CNT_WD:0]                 byte_insert_cnt,
    input  logic                                 ready_insert,
    input  logic                                 mon_valid_out,
    input  logic                                 mon_ready_out,
    input  logic                                 mon_last_out,
    output logic [REQ_ID_WD-1:0]                 grant_id,
    output logic                                 busy,
    output logic                                 err_desc,
    output logic                                 err_timeout
);

    localparam int unsigned StallWd = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [StallWd-1:0] StallLast =
        StallWd'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam int unsigned CntWd = BYTE_CNT_WD + 1;

    logic [3:0]              state_q, state_d;
    logic [REQ_ID_WD-1:0]    rr_ptr_q, rr_ptr_d;
    logic [REQ_ID_WD-1:0]    grant_id_q, grant_id_d;
    logic [DATA_WD-1:0]      hdr_q, hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic [BYTE_CNT_WD:0]    cnt_q, cnt_d;
    logic [StallWd-1:0]      stall_q, stall_d;
    logic                    err_desc_q, err_desc_d;
    logic                    err_timeout_q, err_timeout_d;

    logic [REQ_ID_WD-1:0]    win_id;
    logic                    any_valid;
    logic [DATA_WD-1:0]      sel_hdr;
    logic [DATA_BYTE_WD-1:0] sel_keep;
    logic [BYTE_CNT_WD:0]    sel_cnt;
    logic                    sel_ok;
    logic                    out_beat;

    axis_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_ID_WD(REQ_ID_WD)
    ) u_rr_pick (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr_q),
        .win_id   (win_id),
        .any_valid(any_valid)
    );

    assign sel_hdr  = req_header[32'(grant_id_q) * DATA_WD +: DATA_WD];
    assign sel_keep = req_keep[32'(grant_id_q) * DATA_BYTE_WD +: DATA_BYTE_WD];
    assign sel_cnt  = req_byte_cnt[32'(grant_id_q) * CntWd +: CntWd];
    assign sel_ok   = desc_ok(64'(sel_keep), 32'(sel_cnt), DATA_BYTE_WD);
    assign out_beat = mon_valid_out && mon_ready_out;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        hdr_d         = hdr_q;
        keep_d        = keep_q;
        cnt_d         = cnt_q;
        stall_d       = stall_q;
        err_desc_d    = 1'b0;
        err_timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    grant_id_d = win_id;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                hdr_d    = sel_hdr;
                keep_d   = sel_keep;
                cnt_d    = sel_cnt;
                rr_ptr_d = (32'(grant_id_q) == NUM_REQ - 1) ? '0
                                                            : grant_id_q + REQ_ID_WD'(1);
                if (sel_ok) begin
                    state_d = ST_OFFER;
                end else begin
                    state_d    = ST_IDLE;
                    err_desc_d = 1'b1;
                end
            end
            ST_OFFER: begin
                if (ready_insert) begin
                    state_d = ST_BUSY;
                    stall_d = '0;
                end
            end
            ST_BUSY: begin
                if (out_beat) begin
                    stall_d = '0;
                    if (mon_last_out) state_d = ST_IDLE;
                end else if (TIMEOUT_CYC != 0 && stall_q == StallLast) begin
                    stall_d       = '0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (stall_q != '1) begin
                    stall_d = stall_q + StallWd'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            hdr_q         <= '0;
            keep_q        <= '0;
            cnt_q         <= '0;
            stall_q       <= '0;
            err_desc_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            hdr_q         <= hdr_d;
            keep_q        <= keep_d;
            cnt_q         <= cnt_d;
            stall_q       <= stall_d;
            err_desc_q    <= err_desc_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ST_GRANT) req_ready[grant_id_q] = 1'b1;
    end

    assign valid_insert    = (state_q == ST_OFFER);
    assign busy            = (state_q == ST_GRANT) || (state_q == ST_OFFER) ||
                             (state_q == ST_BUSY);
    assign header_insert   = hdr_q;
    assign keep_insert     = keep_q;
    assign byte_insert_cnt = cnt_q;
    assign grant_id        = grant_id_q;
    assign err_desc        = err_desc_q;
    assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_axis_header_arbiter.sv
// Directed bench for axis_header_arbiter: inputs driven and outputs sampled on falling edges.
module tb_axis_header_arbiter;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 3;
    localparam int NR = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_header = '0;
    logic [NR*BW-1:0] req_keep = '0;
    logic [NR*CW-1:0] req_byte_cnt = '0;
    logic [NR-1:0]   req_ready;
    logic            valid_insert;
    logic [DW-1:0]   header_insert;
    logic [BW-1:0]   keep_insert;
    logic [CW-1:0]   byte_insert_cnt;
    logic            ready_insert = 1'b0;
    logic            mon_valid_out = 1'b0;
    logic            mon_ready_out = 1'b0;
    logic            mon_last_out = 1'b0;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            err_desc;
    logic            err_timeout;

    int n_cmp = 0;
    int n_fail = 0;

    axis_header_arbiter #(
        .DATA_WD    (DW),
        .NUM_REQ    (NR),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_header     (req_header),
        .req_keep       (req_keep),
        .req_byte_cnt   (req_byte_cnt),
        .req_ready      (req_ready),
        .valid_insert   (valid_insert),
        .header_insert  (header_insert),
        .keep_insert    (keep_insert),
        .byte_insert_cnt(byte_insert_cnt),
        .ready_insert   (ready_insert),
        .mon_valid_out  (mon_valid_out),
        .mon_ready_out  (mon_ready_out),
        .mon_last_out   (mon_last_out),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_desc       (err_desc),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] h, input logic [3:0] k,
                           input logic [2:0] c);
        req_valid[i] = 1'b1;
        req_header[i*DW +: DW] = h;
        req_keep[i*BW +: BW] = k;
        req_byte_cnt[i*CW +: CW] = c;
    endtask

    // Three accepted output beats, the last one closing the packet; ends in IDLE.
    task automatic send_packet;
        mon_valid_out = 1'b1;
        mon_ready_out = 1'b1;
        mon_last_out = 1'b0;
        tick;
        tick;
        mon_last_out = 1'b1;
        tick;
        mon_valid_out = 1'b0;
        mon_ready_out = 1'b0;
        mon_last_out = 1'b0;
    endtask

    task automatic test_reset;
        logic [61:0] outs;
        tick;
        tick;
        outs = {req_ready, valid_insert, header_insert, keep_insert, byte_insert_cnt,
                grant_id, busy, err_desc, err_timeout};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b req_ready=%b want 0/0000", busy, req_ready);
        end
    endtask

    task automatic test_round_robin;
        int idle;
        logic [3:0] exp_rdy;
        logic [31:0] exp_hdr;
        for (int i = 0; i < NR; i++) set_req(i, 32'h1000_0000 + 32'(i), 4'hF, 3'd4);
        ready_insert = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle = 0;
            while (busy === 1'b0 && idle < 10) begin
                idle++;
                tick;
            end
            if (k > 0) begin
                n_cmp++;
                if (idle !== 1) begin
                    n_fail++;
                    $display("FAIL rr_gap[%0d]: got %0d idle cycles want 1", k, idle);
                end
            end
            exp_rdy = 4'(1 << (k % 4));
            exp_hdr = 32'h1000_0000 + 32'(k % 4);
            n_cmp++;
            if (req_ready !== exp_rdy || grant_id !== IW'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: req_ready=%b grant_id=%0d want %b/%0d",
                         k, req_ready, grant_id, exp_rdy, k % 4);
            end
            tick;
            if (k == 4) req_valid = '0;
            n_cmp++;
            if (valid_insert !== 1'b1 || header_insert !== exp_hdr) begin
                n_fail++;
                $display("FAIL rr_offer[%0d]: valid=%b header=%h want 1/%h",
                         k, valid_insert, header_insert, exp_hdr);
            end
            tick;
            send_packet;
        end
    endtask

    task automatic test_single;
        set_req(2, 32'hA1B2_C3D4, 4'b0011, 3'd2);
        tick;
        n_cmp++;
        if (req_ready !== 4'b0100 || valid_insert !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: req_ready=%b valid=%b want 0100/0", req_ready,
                     valid_insert);
        end
        tick;
        req_valid = '0;
        n_cmp++;
        if (valid_insert !== 1'b1 || header_insert !== 32'hA1B2_C3D4 ||
            keep_insert !== 4'b0011 || byte_insert_cnt !== 3'd2 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_offer: v=%b h=%h k=%b c=%0d r=%b want 1/a1b2c3d4/0011/2/0000",
                     valid_insert, header_insert, keep_insert, byte_insert_cnt, req_ready);
        end
        tick;
        n_cmp++;
        if (valid_insert !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: valid=%b busy=%b want 0/1", valid_insert, busy);
        end
        send_packet;
        n_cmp++;
        if (busy !== 1'b0 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_done: busy=%b grant_id=%0d want 0/2", busy, grant_id);
        end
    endtask

    task automatic test_bad_desc;
        ready_insert = 1'b0;
        set_req(1, 32'h0BAD_0001, 4'hF, 3'd5);
        tick;
        n_cmp++;
        if (req_ready !== 4'b0010 || valid_insert !== 1'b0) begin
            n_fail++;
            $display("FAIL bad1_grant: req_ready=%b valid=%b want 0010/0", req_ready,
                     valid_insert);
        end
        tick;
        n_cmp++;
        if (err_desc !== 1'b1 || valid_insert !== 1'b0 || busy !== 1'b0 ||
            err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL bad1_err: err_desc=%b valid=%b busy=%b err_to=%b want 1/0/0/0",
                     err_desc, valid_insert, busy, err_timeout);
        end
        set_req(1, 32'h0BAD_0002, 4'b0101, 3'd2);
        tick;
        n_cmp++;
        if (req_ready !== 4'b0010 || err_desc !== 1'b0 || valid_insert !== 1'b0) begin
            n_fail++;
            $display("FAIL bad2_grant: req_ready=%b err=%b valid=%b want 0010/0/0",
                     req_ready, err_desc, valid_insert);
        end
        tick;
        req_valid = '0;
        n_cmp++;
        if (err_desc !== 1'b1 || valid_insert !== 1'b0) begin
            n_fail++;
            $display("FAIL bad2_err: err_desc=%b valid=%b want 1/0", err_desc, valid_insert);
        end
        // With rr_ptr at 2, requester 2 must beat 0 and 3.
        set_req(0, 32'h0000_0A0A, 4'hF, 3'd4);
        set_req(2, 32'hDEAD_BEEF, 4'hF, 3'd4);
        set_req(3, 32'h0000_0B0B, 4'hF, 3'd4);
        tick;
        n_cmp++;
        if (grant_id !== 2'd2 || req_ready !== 4'b0100 || err_desc !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_after_bad: grant_id=%0d req_ready=%b err=%b want 2/0100/0",
                     grant_id, req_ready, err_desc);
        end
    endtask

    task automatic test_offer_stall;
        tick;
        req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (valid_insert !== 1'b1 || header_insert !== 32'hDEAD_BEEF ||
                keep_insert !== 4'hF || byte_insert_cnt !== 3'd4 || err_timeout !== 1'b0 ||
                busy !== 1'b1) begin
                n_fail++;
                $display("FAIL offer_hold[%0d]: v=%b h=%h k=%h c=%0d to=%b busy=%b", i,
                         valid_insert, header_insert, keep_insert, byte_insert_cnt,
                         err_timeout, busy);
            end
            tick;
        end
        ready_insert = 1'b1;
        tick;
        ready_insert = 1'b0;
        n_cmp++;
        if (valid_insert !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL offer_accept: valid=%b busy=%b want 0/1", valid_insert, busy);
        end
    endtask

    task automatic test_timeout;
        for (int i = 1; i <= 7; i++) begin
            tick;
            n_cmp++;
            if (err_timeout !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_early[%0d]: err_to=%b busy=%b want 0/1", i, err_timeout,
                         busy);
            end
        end
        tick;
        n_cmp++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || err_desc !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: err_to=%b busy=%b err_desc=%b want 1/0/0",
                     err_timeout, busy, err_desc);
        end
        tick;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: err_to=%b want 0", err_timeout);
        end
    endtask

    task automatic test_reset_busy;
        logic [61:0] outs;
        ready_insert = 1'b1;
        set_req(1, 32'h5555_0001, 4'hF, 3'd4);
        tick;
        tick;
        req_valid = '0;
        tick;
        n_cmp++;
        if (busy !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset_busy: busy=%b grant_id=%0d want 1/1", busy, grant_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {req_ready, valid_insert, header_insert, keep_insert, byte_insert_cnt,
                grant_id, busy, err_desc, err_timeout};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_busy_outputs: got %h want 0", outs);
        end
        set_req(0, 32'h0000_C0DE, 4'b0111, 3'd3);
        set_req(1, 32'h5555_0001, 4'hF, 3'd4);
        set_req(3, 32'h0000_0B0B, 4'hF, 3'd4);
        tick;
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b grant_id=%0d want 0001/0",
                     req_ready, grant_id);
        end
        tick;
        req_valid = '0;
        n_cmp++;
        if (valid_insert !== 1'b1 || header_insert !== 32'h0000_C0DE ||
            keep_insert !== 4'b0111 || byte_insert_cnt !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_first_offer: v=%b h=%h k=%b c=%0d want 1/0000c0de/0111/3",
                     valid_insert, header_insert, keep_insert, byte_insert_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single;
        test_bad_desc;
        test_offer_stall;
        test_timeout;
        test_reset_busy;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
